axi_lite_txn_sequencer: RTL and testbench

//   Upstream command source for the AXI4-Lite master.
//   - On a start pulse, issues NUM_CMDS write transactions back to back through the master's
//     INT_AXI_TXN / tgt_addr / tgt_data inputs.
//   - Waits for txn_done or txn_error after each transaction, counts passes and errors, and

---
 rtl/axi_lite_txn_sequencer.sv | 176 +++++++++++++++++
 tb/tb_axi_lite_txn_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_txn_sequencer.sv
// Command source for the AXI4-Lite master: on start, issues NUM_CMDS write transactions with
// swept address/data, tallies done/error responses and aborts a stalled transaction by watchdog.
module axi_lite_txn_sequencer #(
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 32,
    parameter int                NUM_CMDS  = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4),
    parameter logic [DATA_W-1:0] DATA_SEED = DATA_W'(32'hA5A5_0000),
    parameter logic [DATA_W-1:0] DATA_STEP = DATA_W'(32'h0000_0101),
    parameter int                TIMEOUT   = 255
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            start,
    output logic                            int_axi_txn,
    output logic [ADDR_W-1:0]               tgt_addr,
    output logic [DATA_W-1:0]               tgt_data,
    input  logic                            txn_done,
    input  logic                            txn_error,
    output logic                            busy,
    output logic                            seq_done,
    output logic [$clog2(NUM_CMDS+1)-1:0]   pass_cnt,
    output logic [$clog2(NUM_CMDS+1)-1:0]   err_cnt,
    output logic                            timeout_flag
);

    localparam int CNT_W = $clog2(NUM_CMDS + 1);
    localparam int IDX_W = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CMDS - 1);
    localparam logic [WD_W-1:0]  TIMEOUT_V = WD_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        FIN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        rst_sync;
    logic              rst_n;
    logic [IDX_W-1:0]  idx;
    logic [WD_W-1:0]   watchdog;
    logic [WD_W-1:0]   wd_nxt;
    logic              first_cmd;
    logic              next_cmd;
    logic              inc_pass;
    logic              inc_err;
    logic              abort;
    logic              wd_inc;

    // Assertion reaches every flop immediately; release is aligned to aclk.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign wd_nxt = watchdog + WD_W'(1);

    always_comb begin
        state_nxt = state;
        first_cmd = 1'b0;
        next_cmd  = 1'b0;
        inc_pass  = 1'b0;
        inc_err   = 1'b0;
        abort     = 1'b0;
        wd_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    first_cmd = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                // Error takes priority when both indications arrive together.
                if (txn_error) begin
                    inc_err   = 1'b1;
                    state_nxt = DRAIN;
                end else if (txn_done) begin
                    inc_pass  = 1'b1;
                    state_nxt = DRAIN;
                end else if (wd_nxt == TIMEOUT_V) begin
                    inc_err   = 1'b1;
                    abort     = 1'b1;
                    state_nxt = FIN;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            DRAIN: begin
                // Level-style indications must fall before the next command is issued.
                if (!txn_done && !txn_error) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = FIN;
                    end else begin
                        next_cmd  = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            watchdog     <= '0;
            tgt_addr     <= '0;
            tgt_data     <= '0;
            pass_cnt     <= '0;
            err_cnt      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (first_cmd) begin
                idx          <= '0;
                tgt_addr     <= BASE_ADDR;
                tgt_data     <= DATA_SEED;
                pass_cnt     <= '0;
                err_cnt      <= '0;
                timeout_flag <= 1'b0;
            end
            // Address and data advance incrementally, wrapping modulo their widths.
            if (next_cmd) begin
                idx      <= idx + IDX_W'(1);
                tgt_addr <= tgt_addr + ADDR_STEP;
                tgt_data <= tgt_data + DATA_STEP;
            end
            if (inc_pass) begin
                pass_cnt <= pass_cnt + CNT_W'(1);
            end
            if (inc_err) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            if (abort) begin
                timeout_flag <= 1'b1;
            end
            if (state == ISSUE) begin
                watchdog <= '0;
            end else if (wd_inc) begin
                watchdog <= wd_nxt;
            end
        end
    end

    assign int_axi_txn = (state == ISSUE);
    assign busy        = (state == ISSUE) || (state == WAIT) || (state == DRAIN);
    assign seq_done    = (state == FIN);

endmodule

// File: tb/tb_axi_lite_txn_sequencer.sv
// Directed bench for axi_lite_txn_sequencer: happy path, error priority, level responses,
// watchdog abort, address wrap, start handling and asynchronous reset.
module tb_axi_lite_txn_sequencer;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic        txn_done;
    logic        txn_error;
    logic        int_axi_txn;
    logic [3:0]  tgt_addr;
    logic [31:0] tgt_data;
    logic        busy;
    logic        seq_done;
    logic [2:0]  pass_cnt;
    logic [2:0]  err_cnt;
    logic        timeout_flag;
    logic        int_axi_txn2;
    logic [3:0]  tgt_addr2;
    logic [31:0] tgt_data2;
    logic        busy2;
    logic        seq_done2;
    logic [2:0]  pass_cnt2;
    logic [2:0]  err_cnt2;
    logic        timeout_flag2;

    int errors = 0;
    int checks = 0;
    int txn_cnt = 0;

    logic [3:0]  ea  [4] = '{4'h0, 4'h4, 4'h8, 4'hC};
    logic [3:0]  ea2 [4] = '{4'hC, 4'h0, 4'h4, 4'h8};
    logic [31:0] ed  [4] = '{32'hA5A5_0000, 32'hA5A5_0101, 32'hA5A5_0202, 32'hA5A5_0303};

    axi_lite_txn_sequencer #(.TIMEOUT(8)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .int_axi_txn(int_axi_txn),
        .tgt_addr(tgt_addr), .tgt_data(tgt_data), .txn_done(txn_done), .txn_error(txn_error),
        .busy(busy), .seq_done(seq_done), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
        .timeout_flag(timeout_flag)
    );

    axi_lite_txn_sequencer #(.TIMEOUT(8), .BASE_ADDR(4'hC)) dut_wrap (
        .aclk(aclk), .aresetn(aresetn), .start(start), .int_axi_txn(int_axi_txn2),
        .tgt_addr(tgt_addr2), .tgt_data(tgt_data2), .txn_done(txn_done), .txn_error(txn_error),
        .busy(busy2), .seq_done(seq_done2), .pass_cnt(pass_cnt2), .err_cnt(err_cnt2),
        .timeout_flag(timeout_flag2)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (int_axi_txn === 1'b1) txn_cnt <= txn_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_seq(input bit keep);
        start = 1'b1;
        step();
        chk("start_latency_pulse", int_axi_txn, 1);
        chk("start_busy", busy, 1);
        chk("start_clear_pass", pass_cnt, 0);
        chk("start_clear_err", err_cnt, 0);
        chk("start_clear_timeout", timeout_flag, 0);
        start = keep;
    endtask

    task automatic wait_pulse(input string tag);
        int n;
        n = 0;
        while (int_axi_txn !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk(tag, int_axi_txn, 1);
    endtask

    task automatic run_cmd(input int k, input bit d, input bit e, input int hold);
        wait_pulse("cmd_pulse");
        chk("cmd_addr", tgt_addr, ea[k]);
        chk("cmd_data", tgt_data, ed[k]);
        chk("cmd_addr_wrap", tgt_addr2, ea2[k]);
        chk("cmd_data_wrap", tgt_data2, ed[k]);
        step();
        chk("cmd_single_pulse", int_axi_txn, 0);
        chk("cmd_busy_wait", busy, 1);
        txn_done  = d;
        txn_error = e;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("cmd_no_pulse_hold", int_axi_txn, 0);
            chk("cmd_addr_stable", tgt_addr, ea[k]);
        end
        txn_done  = 1'b0;
        txn_error = 1'b0;
    endtask

    task automatic finish_seq(input int p, input int er);
        step();
        chk("fin_seq_done", seq_done, 1);
        chk("fin_busy", busy, 0);
        chk("fin_pass", pass_cnt, p);
        chk("fin_err", err_cnt, er);
        chk("fin_timeout", timeout_flag, 0);
        step();
        chk("idle_seq_done", seq_done, 0);
        chk("idle_pass_hold", pass_cnt, p);
        chk("idle_err_hold", err_cnt, er);
        chk("idle_addr_hold", tgt_addr, ea[3]);
        chk("idle_data_hold", tgt_data, ed[3]);
    endtask

    initial begin
        int tc;
        aresetn   = 1'b0;
        start     = 1'b0;
        txn_done  = 1'b0;
        txn_error = 1'b0;
        repeat (3) step();
        chk("rst_int_axi_txn", int_axi_txn, 0);
        chk("rst_busy", busy, 0);
        chk("rst_seq_done", seq_done, 0);
        chk("rst_addr", tgt_addr, 0);
        chk("rst_data", tgt_data, 0);
        chk("rst_pass", pass_cnt, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_timeout", timeout_flag, 0);
        aresetn = 1'b1;
        repeat (4) step();

        // Happy path, with stray start pulses while busy.
        tc = txn_cnt;
        start_seq(1'b0);
        run_cmd(0, 1'b1, 1'b0, 1);
        start = 1'b1;
        run_cmd(1, 1'b1, 1'b0, 1);
        start = 1'b0;
        run_cmd(2, 1'b1, 1'b0, 1);
        run_cmd(3, 1'b1, 1'b0, 1);
        finish_seq(4, 0);
        chk("happy_txn_count", txn_cnt - tc, 4);

        // Done and error together on command 1: error wins.
        tc = txn_cnt;
        start_seq(1'b0);
        run_cmd(0, 1'b1, 1'b0, 1);
        run_cmd(1, 1'b1, 1'b1, 1);
        run_cmd(2, 1'b1, 1'b0, 1);
        run_cmd(3, 1'b1, 1'b0, 1);
        finish_seq(3, 1);
        chk("err_txn_count", txn_cnt - tc, 4);

        // Level-style done held 5 cycles per command.
        tc = txn_cnt;
        start_seq(1'b0);
        for (int k = 0; k < 4; k++) run_cmd(k, 1'b1, 1'b0, 5);
        finish_seq(4, 0);
        chk("level_txn_count", txn_cnt - tc, 4);

        // No response to command 2: watchdog abort after 8 WAIT cycles.
        tc = txn_cnt;
        start_seq(1'b0);
        run_cmd(0, 1'b1, 1'b0, 1);
        run_cmd(1, 1'b1, 1'b0, 1);
        wait_pulse("to_cmd2_pulse");
        step();
        repeat (7) step();
        chk("to_not_yet_done", seq_done, 0);
        chk("to_still_busy", busy, 1);
        step();
        chk("to_seq_done", seq_done, 1);
        chk("to_flag", timeout_flag, 1);
        chk("to_pass", pass_cnt, 2);
        chk("to_err", err_cnt, 1);
        repeat (10) step();
        chk("to_txn_count", txn_cnt - tc, 3);
        chk("to_flag_sticky", timeout_flag, 1);

        // Start held high: back-to-back sequences with counters re-cleared.
        tc = txn_cnt;
        start_seq(1'b1);
        for (int k = 0; k < 4; k++) run_cmd(k, 1'b1, 1'b0, 1);
        step();
        chk("held_fin_seq_done", seq_done, 1);
        chk("held_fin_pass", pass_cnt, 4);
        step();
        chk("held_idle_no_pulse", int_axi_txn, 0);
        step();
        chk("held_restart_pulse", int_axi_txn, 1);
        chk("held_restart_pass_clear", pass_cnt, 0);
        start = 1'b0;
        run_cmd(0, 1'b1, 1'b0, 1);
        run_cmd(1, 1'b1, 1'b0, 1);
        run_cmd(2, 1'b1, 1'b0, 1);
        run_cmd(3, 1'b0, 1'b1, 1);
        finish_seq(3, 1);
        chk("held_txn_count", txn_cnt - tc, 8);

        // Asynchronous reset in the middle of WAIT for command 1.
        start_seq(1'b0);
        run_cmd(0, 1'b1, 1'b0, 1);
        wait_pulse("mid_cmd1_pulse");
        step();
        chk("mid_pre_busy", busy, 1);
        chk("mid_pre_addr", tgt_addr, 4'h4);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_int_axi_txn", int_axi_txn, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_seq_done", seq_done, 0);
        chk("mid_rst_addr", tgt_addr, 0);
        chk("mid_rst_data", tgt_data, 0);
        chk("mid_rst_pass", pass_cnt, 0);
        chk("mid_rst_err", err_cnt, 0);
        chk("mid_rst_timeout", timeout_flag, 0);
        #10;
        aresetn = 1'b1;
        tc = txn_cnt;
        repeat (8) step();
        chk("mid_release_no_pulse", txn_cnt - tc, 0);
        chk("mid_release_busy", busy, 0);
        chk("mid_release_seq_done", seq_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
